imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch memory controller between the core's fetch stage and the instruction SRAM bus. It takes the core's fetch PC, runs a req/gnt/rvalid transaction on the memory side and returns the instruction word to the core. The `inst`/`inst_valid` pair is registered and held under a valid/ready handshake. It also handles pipeline flushes (discarding stale responses), misaligned PCs and memory timeouts.

## Interface
- `ADDR_WIDTH`, 32, fetch/memory address width
- `DATA_WIDTH`, 32, instruction width
- `TIMEOUT`, 255, max cycles in REQ/WAIT/DRAIN before abort; must be ≥2
- `clk` in 1: single clock, all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `pc` in ADDR_WIDTH: fetch address from core
- `fetch_req` in 1: core requests fetch of `pc`
- `flush` in 1: redirect; abandon current fetch
- `inst` out DATA_WIDTH: fetched instruction (0 on error)
- `inst_valid` out 1: `inst` is valid and held until consumed
- `inst_ready` in 1: core consumes `inst`
- `fetch_err` out 1: qualifies `inst_valid`; misaligned or timeout
- `busy` out 1: state ≠ IDLE
- `mem_req` out 1: memory request
- `mem_addr` out ADDR_WIDTH: word address, low 2 bits always 0
- `mem_gnt` in 1: memory accepts request
- `mem_rvalid` in 1: read data valid
- `mem_rdata` in DATA_WIDTH: read data

## Operation
- **States:** IDLE, REQ, WAIT, DRAIN, HOLD.
- **IDLE**
  - `fetch_req && !flush` with `pc[1:0]==0`: latch `pc` into `addr_q` and go to REQ.
  - `fetch_req && !flush` with `pc[1:0]≠0`: go to HOLD with `inst=0`, `fetch_err=1`. No memory access.
  - `flush` has priority over `fetch_req` in the same cycle; the request is dropped and the core re-presents it.
- **REQ**
  - `mem_req=1`, `mem_addr=addr_q`.
  - `mem_req` stays high until `mem_gnt`, even across a flush.
  - On `mem_gnt`: go to WAIT, or to DRAIN if a flush was seen in REQ or in the gnt cycle (`discard` flag).
- **WAIT**
  - On `mem_rvalid`: capture `mem_rdata` into `inst` and go to HOLD.
  - On `flush` without `rvalid`: go to DRAIN.
  - `flush` and `rvalid` in the same cycle: data discarded, go to IDLE.
- **DRAIN:** on `mem_rvalid`, discard the data and go to IDLE.
- **HOLD**
  - `inst_valid=1`.
  - On `inst_ready`: go to IDLE, or directly to REQ (latching `pc`) if `fetch_req && !flush` in the same cycle.
  - On `flush`: drop the instruction and go to IDLE. Flush beats ready.
- **Timeout**
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT/DRAIN.
  - When it reaches `TIMEOUT` in REQ or WAIT: go to HOLD with `inst=0`, `fetch_err=1`.
  - When it reaches `TIMEOUT` in DRAIN: go to IDLE.
  - A later stray `mem_rvalid` is ignored outside WAIT/DRAIN.
- **`mem_rvalid`** is sampled only in WAIT/DRAIN; it is ignored in the gnt cycle itself.
- **Counter width:** `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Timing
- **Reset values:** `inst=0`, `inst_valid=0`, `fetch_err=0`, `busy=0`, `mem_req=0`, `mem_addr=0`; state IDLE, counter 0, `discard=0`.
- **Reset mid-transaction:** abandons it. No response is expected or consumed afterwards.
- **Minimum latency:** `fetch_req` at cycle 0 → `mem_req` at cycle 1 (gnt same cycle) → `rvalid` at cycle 2 → `inst_valid` at cycle 3.
- **Misaligned PC:** `inst_valid`+`fetch_err` at cycle 1.
- **Back-to-back fetches:** one per 3 cycles at zero memory wait.
- **Outputs:** all are registered; no combinational path from `mem_*` inputs to core-side outputs.
- `inst`/`fetch_err` are stable while `inst_valid && !inst_ready`.

## Structure
- Shared package/header `npc_defs`:
  - state encodings
  - `INST_ERR` constant (32'h0)
  - `ADDR_WIDTH`/`DATA_WIDTH` defaults shared with the core stages
- One sub-module, `fetch_timer`: a saturating cycle counter with clear/enable and a `expired` output at `TIMEOUT`.
- FSM, address/data registers and `discard` flag live in the top of this block.

## Test plan
- **Basic fetch:** `pc=0x8000_0000`, `fetch_req` at cycle 0, gnt immediate, `rvalid` at cycle 2 with `0x00100093`, `inst_ready=1` → `mem_addr=0x8000_0000` at cycle 1; `inst=0x00100093`, `inst_valid=1`, `fetch_err=0` at cycle 3; back to IDLE at cycle 4.
- **Backpressure and stalls:** gnt delayed 3 cycles, `rvalid` delayed 2 more, `inst_ready` low for 4 cycles → `mem_req` held through gnt; `inst` stable while not ready; single-cycle consume.
- **Flush while waiting:** `flush` in WAIT, then `rvalid` with `0xDEADBEEF` → no `inst_valid`; `busy` clears after the `rvalid`; the next fetch of `0x8000_0004` returns its own data.
- **Misaligned PC:** `pc=0x8000_0002` → `inst_valid=1`, `fetch_err=1`, `inst=0` at cycle 1; `mem_req` never asserted.
- **Timeout:** `TIMEOUT=4`, gnt given, no `rvalid` → `fetch_err=1`, `inst_valid=1` 4 cycles after REQ entry; a late `rvalid` is ignored.
- **Reset mid-operation:** `rst` in WAIT → next cycle all outputs 0 and state IDLE; a subsequent `rvalid` produces no `inst_valid`.

Source files
------------

// File: rtl/npc_defs.sv
// Definitions shared by the core fetch stages: fetch FSM encodings, error
// instruction value and default bus widths.
package npc_defs;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  // Instruction word returned alongside fetch_err.
  localparam logic [31:0] INST_ERR = 32'h0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } fetchStateT;

endpackage

// File: rtl/fetch_timer.sv
// Saturating cycle counter for fetch timeouts. expired flags the cycle whose
// closing edge brings the count to TIMEOUT.
module fetch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(TIMEOUT);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  logic [CntWidth-1:0] cntQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ <= '0;
    end else if (clear) begin
      cntQ <= '0;
    end else if (enable && (cntQ != CntMax)) begin
      cntQ <= cntQ + CntWidth'(1);
    end
  end

  // >= rather than == so a saturated count still reads as expired.
  assign expired = (cntQ >= CntLast);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: runs one req/gnt/rvalid read per fetch and
// holds the registered instruction for the core under valid/ready.
//
// state   | meaning
// S_IDLE  | no fetch in flight
// S_REQ   | mem_req high, waiting for gnt
// S_WAIT  | granted, waiting for rvalid
// S_DRAIN | granted but flushed, swallow the response
// S_HOLD  | inst/fetch_err presented to the core
module imem_fetch_ctrl
  import npc_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  fetch_req,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  fetch_err,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  fetchStateT            state, nextState;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] instQ, loadData;
  logic                  errQ, loadErr, loadInst;
  logic                  discardQ, launch, pcAligned;
  logic                  timerClear, timerEn, expired;

  assign launch     = fetch_req && !flush;
  assign pcAligned  = (pc[1:0] == 2'b00);
  assign timerClear = (nextState == S_REQ) && (state != S_REQ);
  assign timerEn    = (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timerClear),
    .enable (timerEn),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    loadInst  = 1'b0;
    loadData  = DATA_WIDTH'(INST_ERR);
    loadErr   = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (launch) begin
          if (pcAligned) begin
            nextState = S_REQ;
          end else begin
            nextState = S_HOLD;
            loadInst  = 1'b1;
          end
        end
      end
      S_REQ: begin
        // A flushed fetch that times out has nobody left to report to.
        if (expired) begin
          if (discardQ || flush) begin
            nextState = S_IDLE;
          end else begin
            nextState = S_HOLD;
            loadInst  = 1'b1;
          end
        end else if (mem_gnt) begin
          nextState = (discardQ || flush) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            nextState = S_IDLE;
          end else begin
            nextState = S_HOLD;
            loadInst  = 1'b1;
            loadData  = mem_rdata;
            loadErr   = 1'b0;
          end
        end else if (flush) begin
          nextState = S_DRAIN;
        end else if (expired) begin
          nextState = S_HOLD;
          loadInst  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid || expired) begin
          nextState = S_IDLE;
        end
      end
      S_HOLD: begin
        if (flush) begin
          nextState = S_IDLE;
        end else if (inst_ready) begin
          if (launch && pcAligned) begin
            nextState = S_REQ;
          end else if (launch) begin
            loadInst = 1'b1;
          end else begin
            nextState = S_IDLE;
          end
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ    <= '0;
      instQ    <= '0;
      errQ     <= 1'b0;
      discardQ <= 1'b0;
    end else begin
      if (timerClear) begin
        addrQ    <= {pc[ADDR_WIDTH-1:2], 2'b00};
        discardQ <= 1'b0;
      end else if ((state == S_REQ) && flush) begin
        discardQ <= 1'b1;
      end
      if (loadInst) begin
        instQ <= loadData;
        errQ  <= loadErr;
      end
    end
  end

  always_comb begin
    inst       = instQ;
    fetch_err  = errQ;
    mem_addr   = addrQ;
    inst_valid = (state == S_HOLD);
    busy       = (state != S_IDLE);
    mem_req    = (state == S_REQ);
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: two instances (default and TIMEOUT=4)
// share stimulus and are both tracked by a transaction-level model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        fetch_req = 1'b0, flush = 1'b0, inst_ready = 1'b0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] instA, instB, addrA, addrB;
  logic        validA, validB, errA, errB, busyA, busyB, reqA, reqB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dutA (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .flush(flush),
    .inst(instA), .inst_valid(validA), .inst_ready(inst_ready), .fetch_err(errA),
    .busy(busyA), .mem_req(reqA), .mem_addr(addrA), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  imem_fetch_ctrl #(.TIMEOUT(4)) dutB (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .flush(flush),
    .inst(instB), .inst_valid(validB), .inst_ready(inst_ready), .fetch_err(errB),
    .busy(busyB), .mem_req(reqB), .mem_addr(addrB), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    fetch_req  = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Model: per instance, which phase of a fetch is outstanding and how many
  // cycles the memory side has been occupied.
  int          mTimeout [2] = '{255, 4};
  bit          mOn = 1'b0;
  bit          mAsking [2], mOwed [2], mDropping [2], mHolding [2], mDoomed [2];
  bit          mErr [2];
  logic [31:0] mAddr [2], mInst [2];
  int          mAge [2];

  task automatic mHoldErr(input int k);
    mHolding[k] = 1'b1;
    mInst[k]    = 32'h0;
    mErr[k]     = 1'b1;
  endtask

  task automatic mStart(input int k);
    if (pc[1:0] != 2'b00) begin
      mHoldErr(k);
    end else begin
      mAsking[k] = 1'b1;
      mAddr[k]   = pc;
      mAge[k]    = 0;
      mDoomed[k] = 1'b0;
    end
  endtask

  always @(posedge clk) begin : modelStep
    bit launch, late;
    launch = fetch_req && !flush;
    for (int k = 0; k < 2; k++) begin
      late = (mAge[k] + 1 >= mTimeout[k]);
      if (rst) begin
        mOn = 1'b1;
        mAsking[k] = 1'b0; mOwed[k] = 1'b0; mDropping[k] = 1'b0;
        mHolding[k] = 1'b0; mDoomed[k] = 1'b0;
        mErr[k] = 1'b0; mInst[k] = '0; mAddr[k] = '0; mAge[k] = 0;
      end else if (mHolding[k]) begin
        if (flush) mHolding[k] = 1'b0;
        else if (inst_ready) begin
          mHolding[k] = 1'b0;
          if (launch) mStart(k);
        end
      end else if (mAsking[k]) begin
        mDoomed[k] = mDoomed[k] || flush;
        if (late) begin
          mAsking[k] = 1'b0;
          if (!mDoomed[k]) mHoldErr(k);
        end else if (mem_gnt) begin
          mAsking[k] = 1'b0;
          if (mDoomed[k]) mDropping[k] = 1'b1;
          else mOwed[k] = 1'b1;
        end
        mAge[k]++;
      end else if (mOwed[k]) begin
        if (mem_rvalid) begin
          mOwed[k] = 1'b0;
          if (!flush) begin
            mHolding[k] = 1'b1; mInst[k] = mem_rdata; mErr[k] = 1'b0;
          end
        end else if (flush) begin
          mOwed[k] = 1'b0; mDropping[k] = 1'b1;
        end else if (late) begin
          mOwed[k] = 1'b0; mHoldErr(k);
        end
        mAge[k]++;
      end else if (mDropping[k]) begin
        if (mem_rvalid || late) mDropping[k] = 1'b0;
        mAge[k]++;
      end else if (launch) begin
        mStart(k);
      end
    end
  end

  always @(negedge clk) begin
    if (mOn) begin
      for (int k = 0; k < 2; k++) begin
        string tag;
        logic [31:0] dInst, dAddr;
        logic dValid, dErr, dBusy, dReq;
        tag    = (k == 0) ? "A" : "B";
        dInst  = (k == 0) ? instA  : instB;
        dAddr  = (k == 0) ? addrA  : addrB;
        dValid = (k == 0) ? validA : validB;
        dErr   = (k == 0) ? errA   : errB;
        dBusy  = (k == 0) ? busyA  : busyB;
        dReq   = (k == 0) ? reqA   : reqB;
        chk({tag, " busy"}, dBusy, mAsking[k] | mOwed[k] | mDropping[k] | mHolding[k]);
        chk({tag, " mem_req"}, dReq, mAsking[k]);
        chk({tag, " inst_valid"}, dValid, mHolding[k]);
        if (mAsking[k]) chk({tag, " mem_addr"}, dAddr, mAddr[k]);
        if (mHolding[k]) begin
          chk({tag, " inst"}, dInst, mInst[k]);
          chk({tag, " fetch_err"}, dErr, mErr[k]);
        end
      end
    end
  end

  initial begin
    quiet();
    rst = 1'b1;
    repeat (2) tick();
    chk("reset inst", instA, 32'h0);
    chk("reset inst_valid", validA, 0);
    chk("reset fetch_err", errA, 0);
    chk("reset busy", busyA, 0);
    chk("reset mem_req", reqA, 0);
    chk("reset mem_addr", addrA, 32'h0);
    rst = 1'b0;
    tick();

    // basic fetch
    pc = 32'h8000_0000; fetch_req = 1'b1; tick();
    chk("basic c1 mem_req", reqA, 1);
    chk("basic c1 mem_addr", addrA, 32'h8000_0000);
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    chk("basic c2 inst_valid", validA, 0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093; tick();
    mem_rvalid = 1'b0;
    chk("basic c3 inst_valid", validA, 1);
    chk("basic c3 inst", instA, 32'h0010_0093);
    chk("basic c3 fetch_err", errA, 0);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;
    chk("basic c4 busy", busyA, 0);
    chk("basic c4 inst_valid", validA, 0);

    // stalled gnt/rvalid and backpressure
    pc = 32'h8000_0010; fetch_req = 1'b1; tick();
    fetch_req = 1'b0;
    repeat (3) begin
      chk("stall mem_req held", reqA, 1);
      tick();
    end
    chk("stall mem_req at gnt", reqA, 1);
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0;
    chk("stall mem_req after gnt", reqA, 0);
    chk("stall B timed out valid", validB, 1);
    chk("stall B timed out err", errB, 1);
    repeat (2) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; tick();
    mem_rvalid = 1'b0;
    repeat (4) begin
      chk("stall inst stable", instA, 32'h1234_5678);
      chk("stall inst_valid held", validA, 1);
      tick();
    end
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;
    chk("stall consumed A", validA, 0);
    chk("stall consumed B", validB, 0);

    // flush while waiting
    pc = 32'h8000_0020; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("flushwait busy draining", busyA, 1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("flushwait busy before rvalid", busyA, 1);
    tick();
    mem_rvalid = 1'b0;
    chk("flushwait busy cleared", busyA, 0);
    chk("flushwait no inst_valid", validA, 0);
    pc = 32'h8000_0004; fetch_req = 1'b1; tick();
    fetch_req = 1'b0;
    chk("flushwait next mem_addr", addrA, 32'h8000_0004);
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; tick();
    mem_rvalid = 1'b0;
    chk("flushwait next inst", instA, 32'hCAFE_F00D);
    chk("flushwait next valid", validA, 1);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;

    // flush while requesting: mem_req held, response discarded
    pc = 32'h8000_0040; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("flushreq mem_req held", reqA, 1);
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; tick();
    mem_rvalid = 1'b0;
    chk("flushreq no inst_valid", validA, 0);
    chk("flushreq idle", busyA, 0);

    // flush and rvalid together
    pc = 32'h8000_0050; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; flush = 1'b1; mem_rdata = 32'h5555_5555; tick();
    quiet();
    chk("flushrv idle", busyA, 0);
    chk("flushrv no inst_valid", validA, 0);

    // flush beats fetch_req in idle
    pc = 32'h8000_0058; fetch_req = 1'b1; flush = 1'b1; tick();
    quiet();
    chk("idleflush no busy", busyA, 0);
    chk("idleflush no mem_req", reqA, 0);

    // flush beats ready in hold
    pc = 32'h8000_0060; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; tick();
    mem_rvalid = 1'b0;
    chk("holdflush valid", validA, 1);
    inst_ready = 1'b1; flush = 1'b1; tick();
    quiet();
    chk("holdflush dropped", validA, 0);
    chk("holdflush idle", busyA, 0);

    // back-to-back
    pc = 32'h8000_0100; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1110_0093; tick();
    mem_rvalid = 1'b0;
    chk("b2b first inst", instA, 32'h1110_0093);
    inst_ready = 1'b1; fetch_req = 1'b1; pc = 32'h8000_0104; tick();
    inst_ready = 1'b0; fetch_req = 1'b0;
    chk("b2b second mem_req", reqA, 1);
    chk("b2b second mem_addr", addrA, 32'h8000_0104);
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2220_0093; tick();
    mem_rvalid = 1'b0;
    chk("b2b second inst", instA, 32'h2220_0093);
    chk("b2b second valid", validA, 1);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;

    // misaligned pc
    pc = 32'h8000_0002; fetch_req = 1'b1; tick();
    fetch_req = 1'b0;
    chk("misalign valid", validA, 1);
    chk("misalign err", errA, 1);
    chk("misalign inst", instA, 32'h0);
    chk("misalign no mem_req", reqA, 0);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;
    chk("misalign consumed", busyA, 0);

    // timeout (instance B, TIMEOUT=4)
    rst = 1'b1; tick();
    rst = 1'b0;
    pc = 32'h8000_0030; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; tick();
    tick();
    chk("timeout B not yet", validB, 0);
    tick();
    chk("timeout B valid", validB, 1);
    chk("timeout B err", errB, 1);
    chk("timeout B inst", instB, 32'h0);
    chk("timeout A still busy", busyA, 1);
    chk("timeout A not valid", validA, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; tick();
    mem_rvalid = 1'b0;
    chk("timeout B late rvalid ignored", instB, 32'h0);
    chk("timeout B err kept", errB, 1);
    chk("timeout A got data", instA, 32'h1111_1111);
    chk("timeout A valid", validA, 1);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0;
    chk("timeout B consumed", busyB, 0);

    // reset mid-transaction
    pc = 32'h8000_0070; fetch_req = 1'b1; tick();
    fetch_req = 1'b0; mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst inst", instA, 32'h0);
    chk("midrst inst_valid", validA, 0);
    chk("midrst fetch_err", errA, 0);
    chk("midrst busy", busyA, 0);
    chk("midrst mem_req", reqA, 0);
    chk("midrst mem_addr", addrA, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; tick();
    mem_rvalid = 1'b0;
    chk("midrst stray rvalid A", validA, 0);
    chk("midrst stray rvalid busy", busyA, 0);
    chk("midrst stray rvalid B", validB, 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
